// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares the single-port framebuffer between scan-out reads
// (absolute priority), a full-buffer clear engine and a queued pixel-write port.
// Grant and framebuffer strobes are combinational from current inputs/state.
module fb_port_arbiter #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned XW         = 8,
  parameter int unsigned YW         = 8,
  parameter int unsigned CW         = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          scan_re,
  input  logic [XW-1:0]                 scan_x,
  input  logic [YW-1:0]                 scan_y,
  output logic [CW-1:0]                 scan_color,
  output logic                          scan_valid,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [XW-1:0]                 wr_x,
  input  logic [YW-1:0]                 wr_y,
  input  logic [CW-1:0]                 wr_color,
  input  logic                          clr_start,
  input  logic [CW-1:0]                 clr_color,
  output logic                          clr_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          fb_we,
  output logic                          fb_re,
  output logic [XW-1:0]                 fb_x,
  output logic [YW-1:0]                 fb_y,
  output logic [CW-1:0]                 fb_wc,
  input  logic [CW-1:0]                 fb_rc
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned EW = XW + YW + CW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;

  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [LW-1:0] count;
  logic [LW-1:0] count_nxt;
  logic [EW-1:0] head;

  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic [CW-1:0] clr_col;

  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          clr_grant;
  logic          clr_last;

  // Handshake and per-cycle grant qualifiers
  assign fifo_empty = (count == '0);
  assign wr_ready   = !rst && (state == ST_IDLE) && (count < LW'(FIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign clr_grant  = !scan_re && (state == ST_CLEAR);
  assign pop        = !scan_re && (state != ST_CLEAR) && !fifo_empty;
  assign clr_last   = (&clr_x) && (&clr_y);
  assign head       = fifo_mem[rd_ptr];

  assign scan_color = fb_rc;
  assign fifo_level = count;
  assign clr_busy   = !rst && ((state == ST_DRAIN) || (state == ST_CLEAR));

  // Occupancy after this cycle's push/pop, used for the DRAIN->CLEAR hand-off
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + LW'(1);
      2'b01:   count_nxt = count - LW'(1);
      default: count_nxt = count;
    endcase
  end

  // Framebuffer port mux: scan read, then clear, then queued write
  always_comb begin
    fb_we = 1'b0;
    fb_re = 1'b0;
    fb_x  = '0;
    fb_y  = '0;
    fb_wc = '0;
    if (scan_re) begin
      fb_re = 1'b1;
      fb_x  = scan_x;
      fb_y  = scan_y;
    end else if (state == ST_CLEAR) begin
      fb_we = 1'b1;
      fb_x  = clr_x;
      fb_y  = clr_y;
      fb_wc = clr_col;
    end else if (!fifo_empty) begin
      fb_we = 1'b1;
      {fb_x, fb_y, fb_wc} = head;
    end
  end

  // Next-state logic; queued writes always land before a clear starts
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt = (count_nxt == '0) ? ST_CLEAR : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (count_nxt == '0) begin
          state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (clr_grant && clr_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Clear colour is captured only when a clear is actually accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_col <= '0;
    end else if ((state == ST_IDLE) && clr_start) begin
      clr_col <= clr_color;
    end
  end

  // Row-major clear counter; wraps back to (0,0) after the final pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_x <= '0;
      clr_y <= '0;
    end else if (clr_grant) begin
      if (&clr_x) begin
        clr_x <= '0;
        clr_y <= clr_y + YW'(1);
      end else begin
        clr_x <= clr_x + XW'(1);
      end
    end
  end

  // Write-queue pointers and occupancy; reset discards queued entries
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Write-queue storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {wr_x, wr_y, wr_color};
    end
  end

  // Read-data valid tracks the framebuffer's one-cycle read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_valid <= 1'b0;
    end else begin
      scan_valid <= scan_re;
    end
  end

endmodule
